// File: rtl/idu_pipe_pkg.sv
// Shared decode types for the NPC decode stage: operation classes, immediate
// formats, RV32 base opcodes and the opcode-level decode/immediate helpers.
package idu_pipe_pkg;

  typedef enum logic [3:0] {
    OP_ALU_R   = 4'd0,
    OP_ALU_I   = 4'd1,
    OP_LOAD    = 4'd2,
    OP_STORE   = 4'd3,
    OP_BRANCH  = 4'd4,
    OP_JAL     = 4'd5,
    OP_JALR    = 4'd6,
    OP_LUI     = 4'd7,
    OP_AUIPC   = 4'd8,
    OP_SYSTEM  = 4'd9,
    OP_ILLEGAL = 4'd10
  } op_class_e;

  typedef enum logic [2:0] {
    IMM_NONE  = 3'd0,
    IMM_I     = 3'd1,
    IMM_SHAMT = 3'd2,
    IMM_S     = 3'd3,
    IMM_B     = 3'd4,
    IMM_U     = 3'd5,
    IMM_J     = 3'd6
  } imm_type_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef struct packed {
    op_class_e op;
    imm_type_e imm_type;
    logic      use_rs1;
    logic      use_rs2;
    logic      reg_write;
    logic      mem_ren;
    logic      mem_wen;
  } dec_ctrl_t;

  function automatic dec_ctrl_t decode_opcode(input logic [6:0] opc, input logic [2:0] f3);
    dec_ctrl_t c;
    c.op        = OP_ILLEGAL;
    c.imm_type  = IMM_NONE;
    c.use_rs1   = 1'b0;
    c.use_rs2   = 1'b0;
    c.reg_write = 1'b0;
    c.mem_ren   = 1'b0;
    c.mem_wen   = 1'b0;
    case (opc)
      OPC_OP: begin
        c.op = OP_ALU_R; c.use_rs1 = 1'b1; c.use_rs2 = 1'b1; c.reg_write = 1'b1;
      end
      OPC_OP_IMM: begin
        c.op = OP_ALU_I; c.use_rs1 = 1'b1; c.reg_write = 1'b1;
        // SLLI/SRLI/SRAI carry a shift amount, not a signed immediate
        c.imm_type = (f3 == 3'b001 || f3 == 3'b101) ? IMM_SHAMT : IMM_I;
      end
      OPC_LOAD: begin
        c.op = OP_LOAD; c.imm_type = IMM_I; c.use_rs1 = 1'b1;
        c.reg_write = 1'b1; c.mem_ren = 1'b1;
      end
      OPC_STORE: begin
        c.op = OP_STORE; c.imm_type = IMM_S; c.use_rs1 = 1'b1;
        c.use_rs2 = 1'b1; c.mem_wen = 1'b1;
      end
      OPC_BRANCH: begin
        c.op = OP_BRANCH; c.imm_type = IMM_B; c.use_rs1 = 1'b1; c.use_rs2 = 1'b1;
      end
      OPC_JAL: begin
        c.op = OP_JAL; c.imm_type = IMM_J; c.reg_write = 1'b1;
      end
      OPC_JALR: begin
        c.op = OP_JALR; c.imm_type = IMM_I; c.use_rs1 = 1'b1; c.reg_write = 1'b1;
      end
      OPC_LUI: begin
        c.op = OP_LUI; c.imm_type = IMM_U; c.reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        c.op = OP_AUIPC; c.imm_type = IMM_U; c.reg_write = 1'b1;
      end
      OPC_SYSTEM: begin
        c.op = OP_SYSTEM; c.imm_type = IMM_I; c.use_rs1 = 1'b1; c.reg_write = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

  function automatic logic [31:0] gen_imm(input imm_type_e t, input logic [31:0] i);
    logic [31:0] imm;
    case (t)
      IMM_I:     imm = {{20{i[31]}}, i[31:20]};
      IMM_SHAMT: imm = {27'd0, i[24:20]};
      IMM_S:     imm = {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B:     imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      IMM_U:     imm = {i[31:12], 12'd0};
      IMM_J:     imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default:   imm = 32'd0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/idu_pipe_reg_file.sv
// Architectural register file: two combinational read ports, one write port,
// x0 hardwired to zero, optional write-through of the same-cycle writeback.
module idu_pipe_reg_file
  import idu_pipe_pkg::*;
#(
  parameter int REG_ADDR_W    = 4,
  parameter int ENABLE_BYPASS = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] waddr,
  input  logic [31:0]           wdata,
  input  logic [REG_ADDR_W-1:0] raddr1,
  input  logic [REG_ADDR_W-1:0] raddr2,
  output logic [31:0]           rdata1,
  output logic [31:0]           rdata2
);

  localparam int NREG = 1 << REG_ADDR_W;

  logic [31:0] regs [NREG];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= 32'd0;
    end else if (we && waddr != '0) begin
      regs[waddr] <= wdata;
    end
  end

  logic [REG_ADDR_W-1:0] raddr [2];
  logic [31:0]           rdata [2];

  assign raddr[0] = raddr1;
  assign raddr[1] = raddr2;
  assign rdata1   = rdata[0];
  assign rdata2   = rdata[1];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rport
      always_comb begin
        rdata[gi] = regs[raddr[gi]];
        if (raddr[gi] == '0)
          rdata[gi] = 32'd0;
        else if (ENABLE_BYPASS != 0 && we && waddr == raddr[gi])
          rdata[gi] = wdata;
      end
    end
  endgenerate

endmodule

// File: rtl/idu_pipe.sv
// Registered decode stage: decodes the IFU instruction, reads operands, tracks
// in-flight destination registers and presents one bundle to EXU.
module idu_pipe
  import idu_pipe_pkg::*;
#(
  parameter int REG_ADDR_W    = 4,
  parameter int ENABLE_BYPASS = 1,
  parameter int CNT_W         = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_instr,
  input  logic [31:0]           in_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_pc,
  output logic [3:0]            out_op,
  output logic [2:0]            out_func3,
  output logic                  out_func7b,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic [31:0]           out_rs1_data,
  output logic [31:0]           out_rs2_data,
  output logic [31:0]           out_imm,
  output logic                  out_reg_write,
  output logic                  out_mem_ren,
  output logic                  out_mem_wen,
  output logic                  out_illegal,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [31:0]           wb_data,
  input  logic                  flush,
  output logic [CNT_W-1:0]      stall_cnt
);

  localparam int NREG   = 1 << REG_ADDR_W;
  localparam bit NARROW = (REG_ADDR_W == 4);
  localparam bit BYPASS = (ENABLE_BYPASS != 0);

  dec_ctrl_t             ctrl;
  op_class_e             dec_op;
  logic                  dec_use_rs1, dec_use_rs2, dec_reg_write;
  logic                  dec_mem_ren, dec_mem_wen, dec_illegal, range_err;
  logic [REG_ADDR_W-1:0] dec_rs1, dec_rs2, dec_rd;
  logic [31:0]           dec_imm, rs1_data, rs2_data;

  assign dec_rd  = in_instr[7 +: REG_ADDR_W];
  assign dec_rs1 = in_instr[15 +: REG_ADDR_W];
  assign dec_rs2 = in_instr[20 +: REG_ADDR_W];

  always_comb begin
    ctrl    = decode_opcode(in_instr[6:0], in_instr[14:12]);
    dec_imm = gen_imm(ctrl.imm_type, in_instr);
    // RV32E only has 16 registers: bit 4 of any field actually used is illegal
    range_err = NARROW && ((ctrl.use_rs1   && in_instr[19]) ||
                           (ctrl.use_rs2   && in_instr[24]) ||
                           (ctrl.reg_write && in_instr[11]));
    dec_illegal   = (ctrl.op == OP_ILLEGAL) || range_err;
    dec_op        = ctrl.op;
    dec_use_rs1   = ctrl.use_rs1;
    dec_use_rs2   = ctrl.use_rs2;
    dec_reg_write = ctrl.reg_write;
    dec_mem_ren   = ctrl.mem_ren;
    dec_mem_wen   = ctrl.mem_wen;
    if (dec_illegal) begin
      dec_op        = OP_ILLEGAL;
      dec_use_rs1   = 1'b0;
      dec_use_rs2   = 1'b0;
      dec_reg_write = 1'b0;
      dec_mem_ren   = 1'b0;
      dec_mem_wen   = 1'b0;
    end
  end

  idu_pipe_reg_file #(
    .REG_ADDR_W   (REG_ADDR_W),
    .ENABLE_BYPASS(ENABLE_BYPASS)
  ) u_reg_file (
    .clk   (clk),
    .rst   (rst),
    .we    (wb_valid),
    .waddr (wb_rd),
    .wdata (wb_data),
    .raddr1(dec_rs1),
    .raddr2(dec_rs2),
    .rdata1(rs1_data),
    .rdata2(rs2_data)
  );

  logic [NREG-1:0] busy_reg, busy_next;
  logic            clr_rs1, clr_rs2, clr_rd, hazard, issue, kill_write;

  // A retiring write to the same index releases the interlock this cycle
  assign clr_rs1 = BYPASS && wb_valid && wb_rd == dec_rs1;
  assign clr_rs2 = BYPASS && wb_valid && wb_rd == dec_rs2;
  assign clr_rd  = BYPASS && wb_valid && wb_rd == dec_rd;

  assign hazard = (dec_use_rs1   && busy_reg[dec_rs1] && !clr_rs1) ||
                  (dec_use_rs2   && busy_reg[dec_rs2] && !clr_rs2) ||
                  (dec_reg_write && busy_reg[dec_rd]  && !clr_rd);

  assign in_ready   = !rst && !flush && (!out_valid || out_ready) && !hazard;
  assign issue      = in_valid && in_ready;
  assign kill_write = flush && out_valid && out_reg_write;

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_busy
      if (gi == 0) begin : g_zero
        assign busy_next[gi] = 1'b0;
      end else begin : g_reg
        logic set_bit, clr_bit;
        assign set_bit = issue && dec_reg_write && dec_rd == REG_ADDR_W'(gi);
        assign clr_bit = (wb_valid && wb_rd == REG_ADDR_W'(gi)) ||
                         (kill_write && out_rd == REG_ADDR_W'(gi));
        assign busy_next[gi] = set_bit || (busy_reg[gi] && !clr_bit);
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_reg <= '0;
    else     busy_reg <= busy_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_pc        <= 32'd0;
      out_op        <= 4'd0;
      out_func3     <= 3'd0;
      out_func7b    <= 1'b0;
      out_rd        <= '0;
      out_rs1_data  <= 32'd0;
      out_rs2_data  <= 32'd0;
      out_imm       <= 32'd0;
      out_reg_write <= 1'b0;
      out_mem_ren   <= 1'b0;
      out_mem_wen   <= 1'b0;
      out_illegal   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (issue) begin
      out_valid     <= 1'b1;
      out_pc        <= in_pc;
      out_op        <= dec_op;
      out_func3     <= in_instr[14:12];
      out_func7b    <= in_instr[30];
      out_rd        <= dec_rd;
      out_rs1_data  <= rs1_data;
      out_rs2_data  <= rs2_data;
      out_imm       <= dec_imm;
      out_reg_write <= dec_reg_write;
      out_mem_ren   <= dec_mem_ren;
      out_mem_wen   <= dec_mem_wen;
      out_illegal   <= dec_illegal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt <= '0;
    else if (in_valid && !in_ready && !flush && stall_cnt != '1)
      stall_cnt <= stall_cnt + 1'b1;
  end

endmodule

// File: tb/tb_idu_pipe.sv
// Scoreboard bench for idu_pipe (RV32E, bypass on): expected bundles are
// queued at issue and compared field by field when EXU accepts them.
module tb_idu_pipe;

  localparam int RW = 4;

  localparam logic [3:0] ALU_R = 4'd0, ALU_I = 4'd1, LOAD = 4'd2, STORE = 4'd3,
                         BRANCH = 4'd4, JAL = 4'd5, LUI = 4'd7, ILLEGAL = 4'd10;

  logic          clk, rst;
  logic          in_valid, in_ready;
  logic [31:0]   in_instr, in_pc;
  logic          out_valid, out_ready;
  logic [31:0]   out_pc;
  logic [3:0]    out_op;
  logic [2:0]    out_func3;
  logic          out_func7b;
  logic [RW-1:0] out_rd;
  logic [31:0]   out_rs1_data, out_rs2_data, out_imm;
  logic          out_reg_write, out_mem_ren, out_mem_wen, out_illegal;
  logic          wb_valid;
  logic [RW-1:0] wb_rd;
  logic [31:0]   wb_data;
  logic          flush;
  logic [31:0]   stall_cnt;

  idu_pipe #(.REG_ADDR_W(RW), .ENABLE_BYPASS(1), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_op(out_op),
    .out_func3(out_func3), .out_func7b(out_func7b), .out_rd(out_rd),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data), .out_imm(out_imm),
    .out_reg_write(out_reg_write), .out_mem_ren(out_mem_ren), .out_mem_wen(out_mem_wen),
    .out_illegal(out_illegal),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]   pc;
    logic [3:0]    op;
    logic [2:0]    f3;
    logic          f7b;
    logic [RW-1:0] rd;
    logic [31:0]   rs1, rs2, imm;
    logic          rw, ren, wen, ill;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] pc, input logic [3:0] op, input logic [2:0] f3,
                              input logic f7b, input logic [RW-1:0] rd, input logic [31:0] rs1,
                              input logic [31:0] rs2, input logic [31:0] imm, input logic rw,
                              input logic ren, input logic wen, input logic ill);
    exp_t r;
    r.pc = pc; r.op = op; r.f3 = f3; r.f7b = f7b; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2;
    r.imm = imm; r.rw = rw; r.ren = ren; r.wen = wen; r.ill = ill;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] instr, input exp_t x);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = x.pc;
    #1;
    chk("issue_ready", {31'd0, in_ready}, 32'd1);
    if (in_ready) q.push_back(x);
    step();
    in_valid = 1'b0;
  endtask

  // EXU side: every accepted bundle is popped and compared
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready && !flush) begin
      if (q.size() == 0) begin
        chk("spurious_out", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        chk("pc",        out_pc, e.pc);
        chk("op",        {28'd0, out_op}, {28'd0, e.op});
        chk("func3",     {29'd0, out_func3}, {29'd0, e.f3});
        chk("func7b",    {31'd0, out_func7b}, {31'd0, e.f7b});
        chk("rd",        {28'd0, out_rd}, {28'd0, e.rd});
        chk("rs1_data",  out_rs1_data, e.rs1);
        chk("rs2_data",  out_rs2_data, e.rs2);
        chk("imm",       out_imm, e.imm);
        chk("reg_write", {31'd0, out_reg_write}, {31'd0, e.rw});
        chk("mem_ren",   {31'd0, out_mem_ren}, {31'd0, e.ren});
        chk("mem_wen",   {31'd0, out_mem_wen}, {31'd0, e.wen});
        chk("illegal",   {31'd0, out_illegal}, {31'd0, e.ill});
        $display("txn pc=%08h op=%0d rd=%0d rs1=%08h rs2=%08h imm=%08h",
                 out_pc, out_op, out_rd, out_rs1_data, out_rs2_data, out_imm);
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_instr = 32'd0; in_pc = 32'd0; out_ready = 1'b0;
    wb_valid = 1'b0; wb_rd = '0; wb_data = 32'd0; flush = 1'b0;
    step();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    step();
    rst = 1'b0;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_imm", out_imm, 32'd0);
    chk("rst_stall_cnt", stall_cnt, 32'd0);
    chk("idle_in_ready", {31'd0, in_ready}, 32'd1);

    // addi x5,x0,7 then one-cycle latency check
    out_ready = 1'b1;
    send(32'h00700293, mk(32'h100, ALU_I, 3'd0, 1'b0, 4'd5, 0, 0, 32'd7, 1, 0, 0, 0));
    chk("lat_out_valid", {31'd0, out_valid}, 32'd1);
    chk("lat_out_op", {28'd0, out_op}, {28'd0, ALU_I});

    // RAW on x5: add x6,x5,x5 stalls until writeback bypasses it
    in_valid = 1'b1; in_instr = 32'h00528333; in_pc = 32'h104;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("raw_in_ready", {31'd0, in_ready}, 32'd0);
      step();
    end
    chk("raw_stall_cnt", stall_cnt, 32'd3);
    wb_valid = 1'b1; wb_rd = 4'd5; wb_data = 32'd7;
    #1;
    chk("raw_bypass_ready", {31'd0, in_ready}, 32'd1);
    if (in_ready) q.push_back(mk(32'h104, ALU_R, 3'd0, 1'b0, 4'd6, 32'd7, 32'd7, 0, 1, 0, 0, 0));
    step();
    wb_valid = 1'b0; in_valid = 1'b0;

    // Backpressure: hold add bundle for 3 cycles with ori x10,x5,15 waiting
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00F2E513; in_pc = 32'h108;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_out_pc", out_pc, 32'h104);
      chk("bp_out_rs1", out_rs1_data, 32'd7);
      chk("bp_out_rd", {28'd0, out_rd}, 32'd6);
      step();
    end
    chk("bp_stall_cnt", stall_cnt, 32'd6);
    out_ready = 1'b1;
    in_valid = 1'b0;
    send(32'h00F2E513, mk(32'h108, ALU_I, 3'd6, 1'b0, 4'd10, 32'd7, 0, 32'd15, 1, 0, 0, 0));

    // Flush a held lw x8,0(x2)
    in_valid = 1'b1; in_instr = 32'h00012403; in_pc = 32'h10C;
    #1;
    chk("lw_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b1;
    #1;
    chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
    chk("held_lw_valid", {31'd0, out_valid}, 32'd1);
    chk("held_lw_ren", {31'd0, out_mem_ren}, 32'd1);
    step();
    flush = 1'b0;
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);

    // Flush with nothing held: only blocks intake for that cycle, no stall count
    out_ready = 1'b1; flush = 1'b1;
    in_valid = 1'b1; in_instr = 32'h00100413; in_pc = 32'h110;
    #1;
    chk("flush_idle_ready", {31'd0, in_ready}, 32'd0);
    step();
    flush = 1'b0;
    chk("flush_idle_valid", {31'd0, out_valid}, 32'd0);
    // addi x8,x0,1 accepted at once: busy[8] was released by the flush
    send(32'h00100413, mk(32'h110, ALU_I, 3'd0, 1'b0, 4'd8, 0, 0, 32'd1, 1, 0, 0, 0));

    // Back-to-back stream covering formats and illegal cases
    send(32'hFE512E23, mk(32'h114, STORE, 3'd2, 1'b1, 4'd12, 0, 32'd7, 32'hFFFFFFFC, 0, 0, 1, 0));
    send(32'hFFF28613, mk(32'h118, ALU_I, 3'd0, 1'b1, 4'd12, 32'd7, 0, 32'hFFFFFFFF, 1, 0, 0, 0));
    send(32'h4032D693, mk(32'h11C, ALU_I, 3'd5, 1'b1, 4'd13, 32'd7, 0, 32'd3, 1, 0, 0, 0));
    send(32'h002088B3, mk(32'h120, ILLEGAL, 3'd0, 1'b0, 4'd1, 0, 0, 0, 0, 0, 0, 1));
    send(32'h0000007F, mk(32'h124, ILLEGAL, 3'd0, 1'b0, 4'd0, 0, 0, 0, 0, 0, 0, 1));
    send(32'h00308593, mk(32'h128, ALU_I, 3'd0, 1'b0, 4'd11, 0, 0, 32'd3, 1, 0, 0, 0));
    send(32'hFE000CE3, mk(32'h12C, BRANCH, 3'd0, 1'b1, 4'd9, 0, 0, 32'hFFFFFFF8, 0, 0, 0, 0));
    send(32'h123453B7, mk(32'h130, LUI, 3'd5, 1'b0, 4'd7, 0, 0, 32'h12345000, 1, 0, 0, 0));
    send(32'h010000EF, mk(32'h134, JAL, 3'd0, 1'b0, 4'd1, 0, 0, 32'd16, 1, 0, 0, 0));
    chk("stream_stall_cnt", stall_cnt, 32'd6);

    // Async reset mid-cycle with addi x3,x0,1 held and busy[3] set
    in_valid = 1'b1; in_instr = 32'h00100193; in_pc = 32'h138;
    #1;
    chk("x3_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_stall_cnt", stall_cnt, 32'd0);
    chk("arst_out_pc", out_pc, 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    // add x4,x3,x5: x3 no longer busy, register file cleared
    send(32'h00518233, mk(32'h200, ALU_R, 3'd0, 1'b0, 4'd4, 0, 0, 0, 1, 0, 0, 0));
    step();
    step();
    chk("queue_drained", q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
